// File: rtl/ddr2_i2c_target_if.sv
// ddr2_i2c_target_if: Avalon-MM register-file bus of the DDR2 I2C target.
//   address[1:0]    register select (R0..R3)
//   chipselect      access strobe
//   write_n         0 = write, 1 = read
//   writedata[31:0] write data (only [7:0] is stored)
//   readdata[31:0]  combinational read data, {24'b0, R[address]}
// Modports: master (bus initiator), slave (register file).
interface ddr2_i2c_target_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/ddr2_i2c_target.sv
// ddr2_i2c_target: I2C target exposing four 8-bit registers R0..R3, also reachable from an
// Avalon-MM slave port. The I2C protocol is a byte pointer write followed by data writes, or a
// (repeated-START) read that streams R[ptr], R[ptr+1], ... with the pointer wrapping 3 -> 0.
//
// Ports:
//   clk     system clock, all state on its rising edge
//   reset   asynchronous active-high reset
//   scl_in  raw SCL pad level (asynchronous)
//   sda_in  raw SDA pad level (asynchronous)
//   sda_oe  1 = pull SDA low, 0 = release
//   busy    high while this target is addressed (address ACK until STOP / ignore)
//   avs     Avalon-MM register-file port (ddr2_i2c_target_if.slave)
//
// Build option: define I2C_TARGET_GLITCH_FILTER_EN to insert a 3-sample agreement filter on
// SCL/SDA after the synchronisers (2 extra cycles of latency).
module ddr2_i2c_target #(
  parameter logic [6:0] DEV_ADDR = 7'h50
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             scl_in,
  input  logic             sda_in,
  output logic             sda_oe,
  output logic             busy,
  ddr2_i2c_target_if.slave avs
);

  typedef enum logic [3:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StPtr,
    StPtrAck,
    StWdata,
    StWdataAck,
    StRdata,
    StRdataAck,
    StIgnore
  } state_e;

  logic [1:0] scl_sync_q, sda_sync_q;
  logic       scl_lvl, sda_lvl;
  logic       scl_prev_q, sda_prev_q;
  logic       scl_rise, scl_fall, start_det, stop_det;

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] sr_q, sr_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] ptr_inc;
  logic       sda_oe_q, sda_oe_d;
  logic       busy_q, busy_d;
  logic       rw_q, rw_d;
  logic [7:0] byte_in;
  logic       i2c_we;
  logic [7:0] i2c_wdata;
  logic [7:0] regs_q [4];
  logic [7:0] regs_d [4];
  logic       avs_we;
  logic       unused_wdata;

  // Synchronisers reset to 1 so an idle (pulled-up) bus produces no edges after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_in};
      sda_sync_q <= {sda_sync_q[0], sda_in};
    end
  end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  logic [1:0] scl_hist_q, sda_hist_q;
  logic       scl_filt_q, sda_filt_q;

  // Level follows the input only once three consecutive samples agree.
  assign scl_lvl = (scl_sync_q[1] == scl_hist_q[0] && scl_hist_q[0] == scl_hist_q[1]) ?
                   scl_sync_q[1] : scl_filt_q;
  assign sda_lvl = (sda_sync_q[1] == sda_hist_q[0] && sda_hist_q[0] == sda_hist_q[1]) ?
                   sda_sync_q[1] : sda_filt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_hist_q <= 2'b11;
      sda_hist_q <= 2'b11;
      scl_filt_q <= 1'b1;
      sda_filt_q <= 1'b1;
    end else begin
      scl_hist_q <= {scl_hist_q[0], scl_sync_q[1]};
      sda_hist_q <= {sda_hist_q[0], sda_sync_q[1]};
      scl_filt_q <= scl_lvl;
      sda_filt_q <= sda_lvl;
    end
  end
`else
  assign scl_lvl = scl_sync_q[1];
  assign sda_lvl = sda_sync_q[1];
`endif

  assign scl_rise  = scl_lvl & ~scl_prev_q;
  assign scl_fall  = ~scl_lvl & scl_prev_q;
  assign start_det = scl_lvl & scl_prev_q & sda_prev_q & ~sda_lvl;
  assign stop_det  = scl_lvl & scl_prev_q & ~sda_prev_q & sda_lvl;

  assign byte_in = {sr_q[6:0], sda_lvl};
  assign ptr_inc = ptr_q + 2'd1;

  // Protocol FSM. Bits are sampled on SCL rise; sda_oe is only updated on a detected SCL fall,
  // so SDA never moves while SCL is high. In the ACK states the first fall drives the ACK and
  // the next fall (sda_oe already set) releases it and moves on.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sr_d      = sr_q;
    ptr_d     = ptr_q;
    sda_oe_d  = sda_oe_q;
    busy_d    = busy_q;
    rw_d      = rw_q;
    i2c_we    = 1'b0;
    i2c_wdata = 8'h00;

    if (start_det) begin
      // Repeated START keeps ptr and busy.
      state_d  = StAddr;
      cnt_d    = 3'd0;
      sda_oe_d = 1'b0;
    end else if (stop_det) begin
      state_d  = StIdle;
      cnt_d    = 3'd0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      case (state_q)
        StAddr: begin
          if (scl_rise) begin
            sr_d  = byte_in;
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              rw_d = sda_lvl;
              if (byte_in[7:1] == DEV_ADDR) begin
                state_d = StAddrAck;
                busy_d  = 1'b1;
              end else begin
                state_d = StIgnore;
                busy_d  = 1'b0;
              end
            end
          end
        end
        StAddrAck: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else begin
              cnt_d = 3'd0;
              if (rw_q) begin
                state_d  = StRdata;
                sr_d     = regs_q[ptr_q];
                sda_oe_d = ~regs_q[ptr_q][7];
              end else begin
                state_d  = StPtr;
                sda_oe_d = 1'b0;
              end
            end
          end
        end
        StPtr: begin
          if (scl_rise) begin
            sr_d  = byte_in;
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              ptr_d   = byte_in[1:0];
              state_d = StPtrAck;
            end
          end
        end
        StPtrAck, StWdataAck: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else begin
              sda_oe_d = 1'b0;
              cnt_d    = 3'd0;
              state_d  = StWdata;
            end
          end
        end
        StWdata: begin
          if (scl_rise) begin
            sr_d  = byte_in;
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              i2c_we    = 1'b1;
              i2c_wdata = byte_in;
              ptr_d     = ptr_inc;
              state_d   = StWdataAck;
            end
          end
        end
        StRdata: begin
          if (scl_rise) begin
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              state_d = StRdataAck;
            end
          end else if (scl_fall) begin
            // cnt_q bits already sent; drive the next one, MSB first.
            sda_oe_d = ~sr_q[3'd7 - cnt_q];
          end
        end
        StRdataAck: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
          end else if (scl_rise) begin
            if (sda_lvl) begin
              state_d = StIgnore;
              busy_d  = 1'b0;
            end else begin
              ptr_d   = ptr_inc;
              sr_d    = regs_q[ptr_inc];
              cnt_d   = 3'd0;
              state_d = StRdata;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign avs_we       = avs.chipselect & ~avs.write_n;
  assign unused_wdata = ^avs.writedata[31:8];

  // Avalon is applied last so it wins a same-register collision with I2C.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (i2c_we) begin
      regs_d[ptr_q] = i2c_wdata;
    end
    if (avs_we) begin
      regs_d[avs.address] = avs.writedata[7:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      state_q    <= StIdle;
      cnt_q      <= 3'd0;
      sr_q       <= 8'h00;
      ptr_q      <= 2'd0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      rw_q       <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        regs_q[i] <= 8'h00;
      end
    end else begin
      scl_prev_q <= scl_lvl;
      sda_prev_q <= sda_lvl;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sr_q       <= sr_d;
      ptr_q      <= ptr_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      rw_q       <= rw_d;
      for (int i = 0; i < 4; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign sda_oe       = sda_oe_q;
  assign busy         = busy_q;
  assign avs.readdata = {24'h000000, regs_q[avs.address]};

endmodule

// File: tb/tb_ddr2_i2c_target.sv
// Testbench for ddr2_i2c_target: bit-banged I2C master with an open-drain SDA model, Avalon
// master, and a register/pointer reference model (m_regs, m_ptr) updated by transaction rules.
module tb_ddr2_i2c_target;
  localparam int H = 12;
`ifdef I2C_TARGET_GLITCH_FILTER_EN
  localparam int Lat = 4;
`else
  localparam int Lat = 2;
`endif
  localparam logic [7:0] AddrW = 8'hA0;
  localparam logic [7:0] AddrR = 8'hA1;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic scl_m = 1'b1;
  logic sda_m = 1'b1;
  logic sda_line;
  logic sda_oe;
  logic busy;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   quiet_bad = 0;
  bit   quiet_en = 1'b0;
  logic [7:0] m_regs [4];
  logic [1:0] m_ptr;

  ddr2_i2c_target_if avs_if ();

  ddr2_i2c_target #(.DEV_ADDR(7'h50)) dut (
    .clk    (clk),
    .reset  (reset),
    .scl_in (scl_m),
    .sda_in (sda_line),
    .sda_oe (sda_oe),
    .busy   (busy),
    .avs    (avs_if)
  );

  assign sda_line = sda_m & ~sda_oe;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (quiet_en && (sda_oe !== 1'b0 || busy !== 1'b0)) quiet_bad++;
  end

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    wait_neg(4); sda_m = 1'b1;
    wait_neg(H); scl_m = 1'b1;
    wait_neg(H); sda_m = 1'b0;
    wait_neg(H); scl_m = 1'b0;
  endtask

  task automatic i2c_stop();
    wait_neg(4); sda_m = 1'b0;
    wait_neg(H); scl_m = 1'b1;
    wait_neg(H); sda_m = 1'b1;
    wait_neg(H);
  endtask

  // Optional Avalon pulse timed to land on the cycle the target sees this bit's SCL rise.
  task automatic write_bit(input logic b, input bit pulse = 1'b0, input logic [1:0] pa = 2'd0,
                           input logic [7:0] pd = 8'h00);
    wait_neg(4); sda_m = b;
    wait_neg(H - 4); scl_m = 1'b1;
    if (pulse) begin
      wait_neg(Lat);
      avs_if.address = pa; avs_if.writedata = {24'h0, pd};
      avs_if.chipselect = 1'b1; avs_if.write_n = 1'b0;
      wait_neg(1);
      avs_if.chipselect = 1'b0; avs_if.write_n = 1'b1;
      wait_neg(H - Lat - 1);
    end else begin
      wait_neg(H);
    end
    scl_m = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack, input bit pulse = 1'b0,
                            input logic [1:0] pa = 2'd0, input logic [7:0] pd = 8'h00);
    for (int i = 7; i >= 0; i--) write_bit(d[i], pulse && (i == 0), pa, pd);
    wait_neg(4); sda_m = 1'b1;
    wait_neg(H - 4); scl_m = 1'b1;
    wait_neg(H / 2); ack = ~sda_line;
    wait_neg(H / 2); scl_m = 1'b0;
  endtask

  task automatic read_byte(input bit mack, output logic [7:0] d);
    for (int i = 7; i >= 0; i--) begin
      wait_neg(4); sda_m = 1'b1;
      wait_neg(H - 4); scl_m = 1'b1;
      wait_neg(H / 2); d[i] = sda_line;
      wait_neg(H / 2); scl_m = 1'b0;
    end
    wait_neg(4); sda_m = ~mack;
    wait_neg(H - 4); scl_m = 1'b1;
    wait_neg(H); scl_m = 1'b0;
    wait_neg(4); sda_m = 1'b1;
  endtask

  task automatic av_write(input logic [1:0] a, input logic [7:0] d);
    wait_neg(1);
    avs_if.address = a; avs_if.writedata = {$urandom_range(0, 255), 16'h0, d};
    avs_if.chipselect = 1'b1; avs_if.write_n = 1'b0;
    wait_neg(1);
    avs_if.chipselect = 1'b0; avs_if.write_n = 1'b1;
    m_regs[a] = d;
  endtask

  task automatic av_check(input string name);
    logic [31:0] exp;
    for (int a = 0; a < 4; a++) begin
      avs_if.address = 2'(a);
      #1;
      exp = {24'h0, m_regs[a]};
      n_cmp++;
      if (avs_if.readdata !== exp) begin
        n_fail++;
        $display("FAIL %s R%0d: readdata=%h expected=%h", name, a, avs_if.readdata, exp);
      end
    end
  endtask

  task automatic test_reset();
    n_cmp++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL reset_sda_oe: got %b want 0", sda_oe); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    av_check("reset_regs");
  endtask

  task automatic test_write_basic();
    logic ack;
    i2c_start();
    write_byte(AddrW, ack);
    n_cmp++; if (ack !== 1'b1) begin n_fail++; $display("FAIL wb_addr_ack: got %b want 1", ack); end
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL wb_busy: got %b want 1", busy); end
    write_byte(8'h02, ack);
    n_cmp++; if (ack !== 1'b1) begin n_fail++; $display("FAIL wb_ptr_ack: got %b want 1", ack); end
    write_byte(8'h5A, ack);
    n_cmp++; if (ack !== 1'b1) begin n_fail++; $display("FAIL wb_data_ack: got %b want 1", ack); end
    i2c_stop();
    m_regs[2] = 8'h5A; m_ptr = 2'd3;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wb_busy_stop: got %b want 0", busy); end
    av_check("write_basic");
  endtask

  task automatic test_random_write();
    logic ack;
    logic [7:0] d;
    int n;
    for (int t = 0; t < 4; t++) begin
      m_ptr = 2'($urandom_range(0, 3));
      n = $urandom_range(1, 4);
      i2c_start();
      write_byte(AddrW, ack);
      n_cmp++; if (ack !== 1'b1) begin n_fail++; $display("FAIL rw_addr_ack: got %b want 1", ack); end
      write_byte({6'($urandom), m_ptr}, ack);
      n_cmp++; if (ack !== 1'b1) begin n_fail++; $display("FAIL rw_ptr_ack: got %b want 1", ack); end
      for (int i = 0; i < n; i++) begin
        d = 8'($urandom);
        write_byte(d, ack);
        n_cmp++; if (ack !== 1'b1) begin n_fail++; $display("FAIL rw_data_ack: got %b want 1", ack); end
        m_regs[m_ptr] = d;
        m_ptr = m_ptr + 2'd1;
      end
      i2c_stop();
      av_check("random_write");
    end
  endtask

  task automatic test_read_wrap();
    logic ack;
    logic [7:0] d;
    av_write(2'd0, 8'h0F);
    av_write(2'd1, 8'hF1);
    av_write(2'd3, 8'hC3);
    i2c_start();
    write_byte(AddrW, ack);
    n_cmp++; if (ack !== 1'b1) begin n_fail++; $display("FAIL rd_addr_ack: got %b want 1", ack); end
    write_byte(8'h03, ack);
    n_cmp++; if (ack !== 1'b1) begin n_fail++; $display("FAIL rd_ptr_ack: got %b want 1", ack); end
    m_ptr = 2'd3;
    i2c_start();
    write_byte(AddrR, ack);
    n_cmp++; if (ack !== 1'b1) begin n_fail++; $display("FAIL rd_raddr_ack: got %b want 1", ack); end
    read_byte(1'b1, d);
    n_cmp++; if (d !== m_regs[m_ptr]) begin n_fail++; $display("FAIL rd_byte0: got %h want %h", d, m_regs[m_ptr]); end
    m_ptr = m_ptr + 2'd1;
    read_byte(1'b0, d);
    n_cmp++; if (d !== m_regs[m_ptr]) begin n_fail++; $display("FAIL rd_byte1: got %h want %h", d, m_regs[m_ptr]); end
    n_cmp++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL rd_release: sda_oe=%b want 0", sda_oe); end
    i2c_stop();
    // A NACK must not advance the pointer: a fresh read returns the same register.
    i2c_start();
    write_byte(AddrR, ack);
    n_cmp++; if (ack !== 1'b1) begin n_fail++; $display("FAIL rd2_addr_ack: got %b want 1", ack); end
    read_byte(1'b0, d);
    n_cmp++; if (d !== m_regs[m_ptr]) begin n_fail++; $display("FAIL rd_ptr_kept: got %h want %h", d, m_regs[m_ptr]); end
    i2c_stop();
  endtask

  task automatic test_random_read();
    logic ack;
    logic [7:0] d;
    int n;
    for (int t = 0; t < 3; t++) begin
      for (int a = 0; a < 4; a++) av_write(2'(a), 8'($urandom));
      m_ptr = 2'($urandom_range(0, 3));
      n = $urandom_range(1, 5);
      i2c_start();
      write_byte(AddrW, ack);
      n_cmp++; if (ack !== 1'b1) begin n_fail++; $display("FAIL rr_addr_ack: got %b want 1", ack); end
      write_byte({6'h0, m_ptr}, ack);
      n_cmp++; if (ack !== 1'b1) begin n_fail++; $display("FAIL rr_ptr_ack: got %b want 1", ack); end
      i2c_start();
      write_byte(AddrR, ack);
      n_cmp++; if (ack !== 1'b1) begin n_fail++; $display("FAIL rr_raddr_ack: got %b want 1", ack); end
      for (int i = 0; i < n; i++) begin
        read_byte(i != n - 1, d);
        n_cmp++;
        if (d !== m_regs[m_ptr]) begin
          n_fail++; $display("FAIL rr_data[%0d]: got %h want %h", i, d, m_regs[m_ptr]);
        end
        if (i != n - 1) m_ptr = m_ptr + 2'd1;
      end
      n_cmp++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL rr_release: sda_oe=%b want 0", sda_oe); end
      i2c_stop();
    end
  endtask

  task automatic test_wrong_addr();
    logic ack0, ack1, ack2;
    quiet_bad = 0;
    quiet_en  = 1'b1;
    i2c_start();
    write_byte(8'hA2, ack0);
    write_byte(8'h02, ack1);
    write_byte(8'h99, ack2);
    i2c_stop();
    quiet_en = 1'b0;
    n_cmp++; if (ack0 !== 1'b0) begin n_fail++; $display("FAIL wa_addr_nack: got %b want 0", ack0); end
    n_cmp++; if (ack1 !== 1'b0 || ack2 !== 1'b0) begin
      n_fail++; $display("FAIL wa_data_nack: got %b%b want 00", ack1, ack2);
    end
    n_cmp++; if (quiet_bad !== 0) begin
      n_fail++; $display("FAIL wa_quiet: sda_oe/busy active %0d cycles want 0", quiet_bad);
    end
    av_check("wrong_addr");
  endtask

  task automatic test_stop_mid();
    logic ack;
    logic [7:0] d;
    d = 8'($urandom) ^ m_regs[1];
    i2c_start();
    write_byte(AddrW, ack);
    n_cmp++; if (ack !== 1'b1) begin n_fail++; $display("FAIL sm_addr_ack: got %b want 1", ack); end
    write_byte(8'h01, ack);
    n_cmp++; if (ack !== 1'b1) begin n_fail++; $display("FAIL sm_ptr_ack: got %b want 1", ack); end
    for (int i = 7; i >= 4; i--) write_bit(d[i]);
    i2c_stop();
    n_cmp++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL sm_sda_oe: got %b want 0", sda_oe); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL sm_busy: got %b want 0", busy); end
    av_check("stop_mid");
  endtask

  task automatic test_collision();
    logic ack;
    // Same register: Avalon value survives.
    i2c_start();
    write_byte(AddrW, ack);
    write_byte(8'h01, ack);
    n_cmp++; if (ack !== 1'b1) begin n_fail++; $display("FAIL col_ptr_ack: got %b want 1", ack); end
    write_byte(8'h22, ack, 1'b1, 2'd1, 8'h11);
    i2c_stop();
    m_regs[1] = 8'h11;
    av_check("collision_same");
    // Different registers: both writes land.
    i2c_start();
    write_byte(AddrW, ack);
    write_byte(8'h01, ack);
    write_byte(8'h44, ack, 1'b1, 2'd2, 8'h33);
    i2c_stop();
    m_regs[1] = 8'h44; m_regs[2] = 8'h33;
    av_check("collision_diff");
  endtask

  task automatic test_reset_mid();
    logic ack;
    bit seen;
    for (int a = 0; a < 4; a++) av_write(2'(a), 8'($urandom_range(1, 255)));
    i2c_start();
    for (int i = 7; i >= 0; i--) write_bit(AddrW[i]);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      wait_neg(1);
      if (sda_oe === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    n_cmp++; if (!seen) begin n_fail++; $display("FAIL rm_ack_seen: sda_oe=%b want 1", sda_oe); end
    reset = 1'b1;
    #1;
    n_cmp++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL rm_async_release: sda_oe=%b want 0", sda_oe); end
    wait_neg(2);
    reset = 1'b0;
    for (int a = 0; a < 4; a++) m_regs[a] = 8'h00;
    m_ptr = 2'd0;
    i2c_stop();
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rm_busy: got %b want 0", busy); end
    av_check("reset_mid");
    i2c_start();
    write_byte(AddrW, ack);
    n_cmp++; if (ack !== 1'b1) begin n_fail++; $display("FAIL rm_recover_ack: got %b want 1", ack); end
    write_byte(8'h00, ack);
    write_byte(8'h6D, ack);
    i2c_stop();
    m_regs[0] = 8'h6D;
    av_check("reset_recover");
  endtask

  initial begin
    avs_if.address = 2'd0; avs_if.writedata = 32'h0;
    avs_if.chipselect = 1'b0; avs_if.write_n = 1'b1;
    for (int a = 0; a < 4; a++) m_regs[a] = 8'h00;
    m_ptr = 2'd0;
    wait_neg(3);
    reset = 1'b0;
    wait_neg(3);
    test_reset();
    test_write_basic();
    test_random_write();
    test_read_wrap();
    test_random_read();
    test_wrong_addr();
    test_stop_mid();
    test_collision();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, compared=%0d mismatched=%0d", n_cmp, n_fail);
    $fatal(1, "time limit reached");
  end

endmodule

// File: doc/ddr2_i2c_target.md
DDR2_I2C_TARGET -- requirements
Module: ddr2_i2c_target

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h50, 7-bit I2C target address.
REQ-002 SHALL have port clk  input  1  system clock; all state on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port scl_in  input  1  raw I2C SCL pad level, asynchronous.
REQ-005 SHALL have port sda_in  input  1  raw I2C SDA pad level, asynchronous.
REQ-006 SHALL have port sda_oe  output  1  1 = pull SDA low (open-drain), 0 = release.
REQ-007 SHALL have ports address[1:0], chipselect, write_n (inputs), writedata[31:0] input, readdata[31:0] output: Avalon-MM slave to register file, zero wait states.
REQ-008 SHALL have port busy  output  1  high from START to STOP while addressed.

Function
REQ-009 SHALL hold four 8-bit registers R0..R3, shared by I2C and Avalon.
REQ-010 SHALL synchronise scl_in/sda_in through 2 flops; edges and START/STOP detected on synchronised levels.
REQ-011 SHALL detect START as SDA fall while SCL high, STOP as SDA rise while SCL high; either, in any state, returns FSM to ADDR (START) or IDLE (STOP) next cycle and releases sda_oe.
REQ-012 SHALL sample SDA on SCL rising edge, change sda_oe only on the cycle after an SCL falling edge.
REQ-013 SHALL use states IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
REQ-014 ADDR: shift 8 bits MSB first; if [7:1]==DEV_ADDR go ADDR_ACK (sda_oe=1 for one SCL period), else IGNORE until START/STOP.
REQ-015 After ADDR_ACK: R/W=0 -> PTR; R/W=1 -> RDATA, loading R[ptr].
REQ-016 PTR: 8th bit received -> ptr <= byte[1:0], ACK, then WDATA.
REQ-017 WDATA: byte written to R[ptr] on 8th SCL rise, ACK, ptr increments, 3 wraps to 0.
REQ-018 RDATA: drive sda_oe = ~bit (MSB first) per bit; after 8 bits release SDA and sample master ACK; ACK -> ptr+1, load next byte; NACK -> IGNORE.
REQ-019 Avalon write (chipselect & ~write_n) SHALL update R[address] with writedata[7:0] same edge; readdata = {24'b0, R[address]} combinational.
REQ-020 Simultaneous Avalon and I2C write to same register SHALL resolve with Avalon value retained; different registers both commit.
REQ-021 busy SHALL assert on ADDR_ACK entry and deassert on STOP or IGNORE entry.
REQ-022 Repeated START SHALL keep ptr value (supports write-pointer-then-read).

Reset
REQ-023 On reset: FSM=IDLE, sda_oe=0, busy=0, ptr=0, R0..R3=8'h00, synchronisers=1, bit counter=0.
REQ-024 Reset mid-transfer SHALL release SDA immediately (asynchronously) and ignore bus until next START.

Configuration
REQ-025 Macro I2C_TARGET_GLITCH_FILTER_EN defined: SCL/SDA pass a 3-sample agreement filter after the synchroniser (level changes only after 3 identical consecutive samples), adding 2 cycles latency; undefined: synchronised levels used directly.
REQ-026 Protocol behaviour SHALL be identical with and without the macro for SCL high/low periods >= 8 clk.

Verification
REQ-027 START, 0xA0, 0x02, 0x5A, STOP -> ACK on all three bytes, R2=0x5A, readdata at address 2 = 0x0000005A.
REQ-028 Avalon write R3=0xC3; START, 0xA0, 0x03, rSTART, 0xA1, read 2 bytes (ACK, NACK) -> data 0xC3 then R0, ptr wraps to 0, SDA released after NACK.
REQ-029 START, 0xA2 (wrong address) -> no ACK, sda_oe stays 0, busy stays 0, registers unchanged.
REQ-030 STOP injected after 4 data bits of a write -> FSM IDLE, target register unchanged, sda_oe=0.
REQ-031 Avalon write R1=0x11 on same clk as I2C write of 0x22 to R1 -> R1=0x11.
REQ-032 Reset asserted during ADDR_ACK -> sda_oe=0 within same cycle, R0..R3=0 afterwards.
